// File: rtl/button_debouncer.sv
// Push-button debouncer: synchroniser followed by a LOW/RISE_WAIT/HIGH/FALL_WAIT qualifier.
// Define DEBOUNCE_SYNC_EN for a two-flop synchroniser; leave it undefined for a single input register.
`timescale 1ns/100ps
module button_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic button_db,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    // The cycle that enters a WAIT state already counts as one stable sample.
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_db;
    logic             r_busy;
    logic             w_s;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], button};
        end
    end

    assign w_s = r_sync[1];
`else
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 1'b0;
        end else begin
            r_sync <= button;
        end
    end

    assign w_s = r_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Outputs are registered from the next state so they never glitch.
            r_db    <= (w_state_nxt == HIGH) || (w_state_nxt == FALL_WAIT);
            r_busy  <= (w_state_nxt == RISE_WAIT) || (w_state_nxt == FALL_WAIT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            LOW: begin
                if (w_s) begin
                    w_state_nxt = RISE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RISE_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_DONE) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!w_s) begin
                    w_state_nxt = FALL_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            FALL_WAIT: begin
                if (w_s) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_DONE) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign button_db = r_db;
    assign busy      = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with STABLE_CYCLES=4; follows DEBOUNCE_SYNC_EN for the synchroniser depth.
`timescale 1ns/100ps
module tb_button_debouncer;

    localparam int STABLE = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif

    logic clk;
    logic rst_n;
    logic button;
    logic button_db;
    logic busy;

    int n_chk;
    int n_err;

    button_debouncer #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .button   (button),
        .button_db(button_db),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Reference: a level is accepted once the synchronised input has differed
    // from the accepted level on STABLE consecutive edges.
    logic m_q [SYNC];
    logic m_db;
    int   m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) m_q[k] <= 1'b0;
            m_db  <= 1'b0;
            m_run <= 0;
        end else begin
            m_q[0] <= button;
            for (int k = 1; k < SYNC; k++) m_q[k] <= m_q[k-1];
            if (m_q[SYNC-1] != m_db) begin
                if (m_run + 1 == STABLE) begin
                    m_db  <= m_q[SYNC-1];
                    m_run <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic b;
        logic db;
        logic bsy;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dut_rises;
        int mdl_rises;
        logic prev_dut;
        logic prev_mdl;
        logic v;

        n_chk  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        button = 1'b0;

        // Press then release, expectations from the edge numbering
        for (int i = 0; i < 10; i++) begin
            tbl[i].b   = 1'b1;
            tbl[i].bsy = (i >= SYNC) && (i < SYNC + STABLE - 1);
            tbl[i].db  = (i >= SYNC + STABLE - 1);
        end
        for (int j = 0; j < 10; j++) begin
            tbl[10+j].b   = 1'b0;
            tbl[10+j].bsy = (j >= SYNC) && (j < SYNC + STABLE - 1);
            tbl[10+j].db  = (j < SYNC + STABLE - 1);
        end

        // Reset holds outputs low while the button toggles
        for (int i = 0; i < 5; i++) begin
            button = ~button;
            @(negedge clk);
            chk("reset_db", button_db, 1'b0);
            chk("reset_busy", busy, 1'b0);
        end
        button = 1'b0;
        rst_n  = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            button = tbl[i].b;
            @(negedge clk);
            chk("tbl_db", button_db, tbl[i].db);
            chk("tbl_busy", busy, tbl[i].bsy);
        end
        repeat (3) @(negedge clk);

        // Bounce: 1,1,0 then steady 1
        for (int i = 0; i <= SYNC + 7; i++) begin
            button = (i == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("bounce_db", button_db, logic'(i >= SYNC + 6));
            if (i == SYNC + 1 || i == SYNC + 3) chk("bounce_busy_hi", busy, 1'b1);
            if (i == SYNC + 2) chk("bounce_busy_abort", busy, 1'b0);
        end

        // Release glitch of two cycles must not drop the level
        for (int i = 0; i < 12; i++) begin
            button = (i < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("glitch_db", button_db, 1'b1);
        end
        for (int i = 0; i <= SYNC + 4; i++) begin
            button = 1'b0;
            @(negedge clk);
            chk("release_db", button_db, logic'(i < SYNC + 3));
        end

        // Reset while in FALL_WAIT
        for (int i = 0; i < 8; i++) begin
            button = 1'b1;
            @(negedge clk);
        end
        chk("pre_fall_db", button_db, 1'b1);
        for (int i = 0; i <= SYNC; i++) begin
            button = 1'b0;
            @(negedge clk);
        end
        chk("fallwait_busy", busy, 1'b1);
        chk("fallwait_db", button_db, 1'b1);
        button = 1'b1;
        rst_n  = 1'b0;
        #0.5;
        chk("async_rst_db", button_db, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= SYNC + 4; i++) begin
            @(negedge clk);
            chk("post_rst_db", button_db, logic'(i >= SYNC + 3));
        end

        // Random bounce bursts against the reference
        dut_rises = 0;
        mdl_rises = 0;
        prev_dut  = button_db;
        prev_mdl  = m_db;
        for (int burst = 0; burst < 60; burst++) begin
            v = logic'($urandom_range(0, 1));
            for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
                button = logic'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("rand_db", button_db, m_db);
                    chk("rand_busy", busy, logic'(m_run != 0));
                    if (button_db && !prev_dut) dut_rises++;
                    if (m_db && !prev_mdl) mdl_rises++;
                    prev_dut = button_db;
                    prev_mdl = m_db;
                end
            end
            button = v;
            repeat ($urandom_range(1, 9)) begin
                @(negedge clk);
                chk("rand_db", button_db, m_db);
                chk("rand_busy", busy, logic'(m_run != 0));
                if (button_db && !prev_dut) dut_rises++;
                if (m_db && !prev_mdl) mdl_rises++;
                prev_dut = button_db;
                prev_mdl = m_db;
            end
        end
        n_chk++;
        if (dut_rises != mdl_rises) begin
            n_err++;
            $display("FAIL press_count: got %0d expected %0d", dut_rises, mdl_rises);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
